// File: rtl/exh_chk_pkg.sv
// ---------------------------------------------------------------------------
// exh_chk_pkg
// Shared definitions for the exhaustive sweep checker.
//   state_e     : sweep controller states
//   MAX_LATENCY : deepest DUT/golden pipeline the checker can drain
//   DRAIN_W     : width of the drain countdown (covers 0..MAX_LATENCY)
// ---------------------------------------------------------------------------
package exh_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_LATENCY = 15;
  localparam int DRAIN_W     = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/exhaustive_checker_tag_delay.sv
// ---------------------------------------------------------------------------
// tag_delay
// Delays an issued stimulus vector plus its valid bit by LATENCY cycles so
// that it lines up with the DUT / golden outputs it produced.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid bits)
//   valid_i    : a vector is being issued this cycle
//   tag_i      : the vector being issued
//   valid_o    : delayed valid, LATENCY cycles later
//   tag_o      : delayed vector, LATENCY cycles later
// LATENCY = 0 is a plain combinational pass-through.
// ---------------------------------------------------------------------------
module tag_delay #(
  parameter int WIDTH   = 10,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] tag_o
);

  generate
    if (LATENCY == 0) begin : g_pass
      // With no pipeline there is nothing to clock or reset; this keeps the
      // clock and reset ports visibly consumed.
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst_n;

      assign valid_o = valid_i;
      assign tag_o   = tag_i;
    end else begin : g_pipe
      logic [LATENCY-1:0] valid_q;
      logic [WIDTH-1:0]   tag_q [LATENCY];

      // Valid bits must be cleared by reset so an abandoned sweep never
      // produces a late compare.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= valid_i;
          for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      // Tags are only ever looked at when their valid bit is set, so they
      // are plain data registers without reset.
      always_ff @(posedge clk) begin
        tag_q[0] <= tag_i;
        for (int i = 1; i < LATENCY; i++) begin
          tag_q[i] <= tag_q[i-1];
        end
      end

      assign valid_o = valid_q[LATENCY-1];
      assign tag_o   = tag_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/exhaustive_checker.sv
// ---------------------------------------------------------------------------
// exhaustive_checker
// Sweeps every WIDTH-bit vector into a DUT and its golden model, compares the
// two outputs LATENCY cycles later, counts mismatches (saturating) and keeps
// the first failing vector.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a sweep (honoured only in IDLE or DONE)
//   stim            : vector currently presented to DUT and golden model
//   dut_o, gold_o   : DUT / golden outputs for the vector issued LATENCY ago
//   busy            : sweep in progress (RUN or DRAIN)
//   done            : sweep finished, results held
//   pass            : done with zero mismatches
//   err_cnt         : saturating mismatch count
//   first_err_valid : a mismatch has been captured this sweep
//   first_err_vec   : vector of the first mismatch
// ---------------------------------------------------------------------------
module exhaustive_checker
  import exh_chk_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int LATENCY = 0,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_o,
  input  logic             gold_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_vec
);

  // After the last vector is issued, DRAIN lasts LATENCY cycles; the
  // countdown is loaded with LATENCY-1 and DONE is entered when it hits 0.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    DRAIN_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
  logic [ERR_W-1:0]   errCnt_q, errCnt_d;
  logic               firstErrValid_q, firstErrValid_d;
  logic [WIDTH-1:0]   firstErrVec_q, firstErrVec_d;

  logic               issueValid;
  logic               cmpValid;
  logic [WIDTH-1:0]   cmpTag;
  logic               mismatch;

  assign issueValid = (state_q == RUN);

  tag_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_tagDelay (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (issueValid),
    .tag_i   (stim_q),
    .valid_o (cmpValid),
    .tag_o   (cmpTag)
  );

  assign mismatch = cmpValid && (dut_o != gold_o);

  // All sweep state lives here; reset abandons any sweep and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      stim_q          <= '0;
      drainCnt_q      <= '0;
      errCnt_q        <= '0;
      firstErrValid_q <= 1'b0;
      firstErrVec_q   <= '0;
    end else begin
      state_q         <= state_d;
      stim_q          <= stim_d;
      drainCnt_q      <= drainCnt_d;
      errCnt_q        <= errCnt_d;
      firstErrValid_q <= firstErrValid_d;
      firstErrVec_q   <= firstErrVec_d;
    end
  end

  // Compare bookkeeping comes first; a start in IDLE/DONE then overrides it
  // to clear the results for the new sweep. Compares can only be pending in
  // RUN or DRAIN, so the override never drops a real mismatch.
  always_comb begin
    state_d         = state_q;
    stim_d          = stim_q;
    drainCnt_d      = drainCnt_q;
    errCnt_d        = errCnt_q;
    firstErrValid_d = firstErrValid_q;
    firstErrVec_d   = firstErrVec_q;

    if (mismatch) begin
      if (errCnt_q != '1) begin
        errCnt_d = errCnt_q + ERR_W'(1);
      end
      if (!firstErrValid_q) begin
        firstErrValid_d = 1'b1;
        firstErrVec_d   = cmpTag;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = RUN;
          stim_d          = '0;
          errCnt_d        = '0;
          firstErrValid_d = 1'b0;
          firstErrVec_d   = '0;
        end
      end
      RUN: begin
        // Terminal detection on all-ones: stim parks at 0, never wraps
        // into a second sweep.
        if (stim_q == '1) begin
          stim_d = '0;
          if (LATENCY == 0) begin
            state_d = DONE;
          end else begin
            state_d    = DRAIN;
            drainCnt_d = DRAIN_LOAD;
          end
        end else begin
          stim_d = stim_q + WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drainCnt_q == '0) begin
          state_d = DONE;
        end else begin
          drainCnt_d = drainCnt_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stim            = stim_q;
  assign busy            = (state_q == RUN) || (state_q == DRAIN);
  assign done            = (state_q == DONE);
  assign pass            = done && (errCnt_q == '0);
  assign err_cnt         = errCnt_q;
  assign first_err_valid = firstErrValid_q;
  assign first_err_vec   = firstErrVec_q;

endmodule

// File: tb/tb_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// tb_exhaustive_checker
// Drives sweeps through a 4-bit checker with a 3-deep pipelined DUT/golden
// pair and a 2-bit error counter. Each sweep carries a per-vector fault mask;
// expected results are derived from the mask alone.
// ---------------------------------------------------------------------------
module tb_exhaustive_checker;

  localparam int W      = 4;
  localparam int L      = 3;
  localparam int EW     = 2;
  localparam int N      = 1 << W;
  localparam int DONE_K = N + L;
  localparam int SAT    = (1 << EW) - 1;

  typedef struct {
    logic [N-1:0] mask;
    int           e0;
  } sweep_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          dut_o;
  logic          gold_o;
  logic [W-1:0]  stim;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;
  logic          first_err_valid;
  logic [W-1:0]  first_err_vec;

  sweep_t        sbQ[$];
  logic [N-1:0]  faultMask = '0;
  int            cycle = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [W-1:0]  pipe [L];
  logic [W-1:0]  dutVec;

  exhaustive_checker #(
    .WIDTH   (W),
    .LATENCY (L),
    .ERR_W   (EW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stim            (stim),
    .dut_o           (dut_o),
    .gold_o          (gold_o),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec)
  );

  always #5 clk = ~clk;

  // Environment: a golden 4-input OR and a DUT that differs from it exactly
  // on the vectors flagged in faultMask, both pipelined L cycles deep.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    pipe[0] <= stim;
    for (int i = 1; i < L; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign dutVec = pipe[L-1];
  assign gold_o = |dutVec;
  assign dut_o  = gold_o ^ faultMask[dutVec];

  // Reference model: a sweep's results follow from its fault mask alone.
  function automatic int expErrCount(input logic [N-1:0] m);
    int c = 0;
    for (int i = 0; i < N; i++) begin
      c += int'(m[i]);
    end
    return (c > SAT) ? SAT : c;
  endfunction

  function automatic int expFirstVec(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stim"}, 32'(stim), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " pass"}, 32'(pass), 0);
    checkOutput({tag, " err_cnt"}, 32'(err_cnt), 0);
    checkOutput({tag, " first_err_valid"}, 32'(first_err_valid), 0);
    checkOutput({tag, " first_err_vec"}, 32'(first_err_vec), 0);
  endtask

  // One sweep: set the fault mask, pulse start, optionally pulse start again
  // mid-RUN, then wait (bounded) for done.
  task automatic applyStimulus(input logic [N-1:0] mask, input bit midStart);
    sweep_t s;
    bit     seen;
    @(negedge clk);
    faultMask = mask;
    start     = 1'b1;
    s.mask    = mask;
    s.e0      = cycle + 1;
    sbQ.push_back(s);
    @(negedge clk);
    start = 1'b0;
    if (midStart) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 4 * DONE_K; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done timeout", 32'(done), 1);
    repeat (2) @(negedge clk);
  endtask

  // Start a sweep and kill it with reset partway through RUN.
  task automatic applyResetMidSweep();
    sweep_t s;
    @(negedge clk);
    faultMask = N'(16'h00F0);
    start     = 1'b1;
    s.mask    = faultMask;
    s.e0      = cycle + 1;
    sbQ.push_back(s);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post-reset busy", 32'(busy), 0);
    checkOutput("post-reset stim", 32'(stim), 0);
  endtask

  // Monitor: tracks the sweep at the head of the scoreboard, checks the
  // stim/busy progression each cycle and scores the results when done rises.
  initial begin
    logic   prevDone;
    int     k;
    sweep_t s;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevDone = 1'b0;
      end else begin
        if (sbQ.size() > 0) begin
          k = cycle - sbQ[0].e0;
          if (done && !prevDone) begin
            s = sbQ.pop_front();
            checkOutput("done timing", 32'(k), 32'(DONE_K));
            checkOutput("err_cnt", 32'(err_cnt), 32'(expErrCount(s.mask)));
            checkOutput("first_err_valid", 32'(first_err_valid),
                        32'(s.mask != '0));
            checkOutput("first_err_vec", 32'(first_err_vec),
                        32'(expFirstVec(s.mask)));
            checkOutput("pass", 32'(pass), 32'(s.mask == '0));
            checkOutput("busy at done", 32'(busy), 0);
          end else if (k >= DONE_K) begin
            checkOutput("done rise at expected edge",
                        32'(done && !prevDone), 1);
            void'(sbQ.pop_front());
          end else if (k >= 0) begin
            checkOutput("stim", 32'(stim), 32'((k < N) ? k : 0));
            checkOutput("busy", 32'(busy), 1);
            checkOutput("done low", 32'(done), 0);
          end
        end else if (done && !prevDone) begin
          checkOutput("spurious done", 32'(done), 0);
        end
        prevDone = done;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] m;
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus('0, 1'b0);
    applyStimulus(N'(16'h0020), 1'b0);
    applyStimulus(N'(16'h0204), 1'b1);
    applyStimulus(N'(16'hFFFF), 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) m = N'($urandom);
      else            m = N'($urandom & $urandom & $urandom);
      applyStimulus(m, i == 2);
    end
    applyResetMidSweep();
    applyStimulus(N'(16'h8001), 1'b0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
